// File: rtl/mpe_accumulator_pkg.sv
// Shared constants for the MPE accumulator and the pooling stage that follows it.
// Includes a fixed-width saturating adder for reuse downstream.
package mpe_accumulator_pkg;

    localparam int OUTPUT_HEIGHT = 2;
    localparam int OUTPUT_WIDTH  = 2;
    localparam int OUT_BIN_LEN   = 16;
    localparam int ACC_BIN_LEN   = 32;

    typedef struct packed {
        logic [ACC_BIN_LEN-1:0] val;
        logic                   clamp;
    } sat_res_t;

    // Two's complement add, clamped to the ACC_BIN_LEN range; clamp marks saturation.
    function automatic sat_res_t sat_add(input logic [ACC_BIN_LEN-1:0] a,
                                         input logic [ACC_BIN_LEN-1:0] b);
        sat_res_t             res;
        logic [ACC_BIN_LEN:0] s;
        s         = {a[ACC_BIN_LEN-1], a} + {b[ACC_BIN_LEN-1], b};
        res.clamp = s[ACC_BIN_LEN] ^ s[ACC_BIN_LEN-1];
        res.val   = res.clamp ? {s[ACC_BIN_LEN], {(ACC_BIN_LEN-1){~s[ACC_BIN_LEN]}}}
                              : s[ACC_BIN_LEN-1:0];
        return res;
    endfunction

endpackage

// File: rtl/mpe_accumulator_if.sv
// MPE-side input beats plus the writeback-side tile handshake of the accumulator.
interface mpe_accumulator_if
    import mpe_accumulator_pkg::*;
#(
    parameter int OH    = OUTPUT_HEIGHT,
    parameter int OW    = OUTPUT_WIDTH,
    parameter int IN_W  = OUT_BIN_LEN,
    parameter int ACC_W = ACC_BIN_LEN
);
    logic [OH-1:0][OW-1:0][IN_W-1:0]  in_vals;
    logic                             in_valid;
    logic                             in_last;
    logic                             stall;
    logic [OH-1:0][OW-1:0][ACC_W-1:0] out_vals;
    logic                             out_valid;
    logic                             out_ready;
    logic                             out_ovf;
    logic                             busy;

    modport master (
        output in_vals, in_valid, in_last, out_ready,
        input  stall, out_vals, out_valid, out_ovf, busy
    );

    modport slave (
        input  in_vals, in_valid, in_last, out_ready,
        output stall, out_vals, out_valid, out_ovf, busy
    );

endinterface

// File: rtl/mpe_acc_lane.sv
// One accumulator lane: sign-extend the MPE value, add to the running sum, clamp.
module mpe_acc_lane #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 32
) (
    input  logic [IN_W-1:0]  in_val_i,
    input  logic [ACC_W-1:0] acc_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             clamp_o
);
    logic [ACC_W:0] in_ext;
    logic [ACC_W:0] acc_ext;
    logic [ACC_W:0] sum_w;

    assign in_ext  = {{(ACC_W+1-IN_W){in_val_i[IN_W-1]}}, in_val_i};
    assign acc_ext = {acc_i[ACC_W-1], acc_i};
    assign sum_w   = acc_ext + in_ext;
    // The two top bits disagree exactly when the sum left the ACC_W range.
    assign clamp_o = sum_w[ACC_W] ^ sum_w[ACC_W-1];

    always_comb begin
        sum_o = sum_w[ACC_W-1:0];
        if (clamp_o) sum_o = {sum_w[ACC_W], {(ACC_W-1){~sum_w[ACC_W]}}};
    end

endmodule

// File: rtl/mpe_accumulator.sv
// Sums MPE partial products over one output tile and hands the tile to writeback.
// The result register is the only output buffer; a full, unaccepted result stalls the MPE.
module mpe_accumulator
    import mpe_accumulator_pkg::*;
#(
    parameter int OH    = OUTPUT_HEIGHT,
    parameter int OW    = OUTPUT_WIDTH,
    parameter int IN_W  = OUT_BIN_LEN,
    parameter int ACC_W = ACC_BIN_LEN
) (
    input logic              clk_i,
    input logic              rst_i,
    mpe_accumulator_if.slave bus
);
    typedef logic [OH-1:0][OW-1:0][ACC_W-1:0] acc_arr_t;

    acc_arr_t              acc_q, acc_d;
    acc_arr_t              res_q, res_d;
    acc_arr_t              sum;
    logic [OH-1:0][OW-1:0] clamp;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  sticky_q, sticky_d;
    logic                  busy_q, busy_d;
    logic                  stall;
    logic                  in_fire;
    logic                  any_clamp;

    assign stall     = valid_q & ~bus.out_ready;
    assign in_fire   = bus.in_valid & ~stall;
    assign any_clamp = |clamp;

    for (genvar r = 0; r < OH; r++) begin : g_row
        for (genvar c = 0; c < OW; c++) begin : g_col
            mpe_acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane (
                .in_val_i (bus.in_vals[r][c]),
                .acc_i    (acc_q[r][c]),
                .sum_o    (sum[r][c]),
                .clamp_o  (clamp[r][c])
            );
        end
    end

    always_comb begin
        acc_d    = acc_q;
        res_d    = res_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        busy_d   = busy_q;
        if (valid_q & bus.out_ready) valid_d = 1'b0;
        // A last beat may land in the same cycle the old tile is taken: no bubble.
        if (in_fire) begin
            if (bus.in_last) begin
                res_d    = sum;
                ovf_d    = sticky_q | any_clamp;
                valid_d  = 1'b1;
                acc_d    = '0;
                sticky_d = 1'b0;
                busy_d   = 1'b0;
            end else begin
                acc_d    = sum;
                sticky_d = sticky_q | any_clamp;
                busy_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            res_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            res_q    <= res_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.out_vals  = res_q;
    assign bus.out_valid = valid_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mpe_accumulator.sv
// Directed bench for mpe_accumulator: a wide 2x2 instance and a narrow one for saturation,
// both checked every cycle against a tile-level arithmetic model.
module tb_mpe_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mpe_accumulator_if #(.OH(2), .OW(2), .IN_W(16), .ACC_W(32)) bus0 ();
    mpe_accumulator_if #(.OH(2), .OW(2), .IN_W(8),  .ACC_W(9))  bus1 ();

    mpe_accumulator #(.OH(2), .OW(2), .IN_W(16), .ACC_W(32)) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(bus0));
    mpe_accumulator #(.OH(2), .OW(2), .IN_W(8), .ACC_W(9)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(bus1));

    int in_v      [2][4];
    bit in_valid  [2];
    bit in_last   [2];
    bit out_ready [2];
    int accw      [2] = '{32, 9};

    always_comb begin
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                bus0.in_vals[r][c] = in_v[0][r*2+c][15:0];
                bus1.in_vals[r][c] = in_v[1][r*2+c][7:0];
            end
        bus0.in_valid  = in_valid[0];
        bus0.in_last   = in_last[0];
        bus0.out_ready = out_ready[0];
        bus1.in_valid  = in_valid[1];
        bus1.in_last   = in_last[1];
        bus1.out_ready = out_ready[1];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint dut_val(input int d, input int l);
        if (d == 0) return longint'($signed(bus0.out_vals[l/2][l%2]));
        return longint'($signed(bus1.out_vals[l/2][l%2]));
    endfunction

    function automatic bit [3:0] dut_flags(input int d);
        if (d == 0) return {bus0.stall, bus0.out_valid, bus0.busy, bus0.out_ovf};
        return {bus1.stall, bus1.out_valid, bus1.busy, bus1.out_ovf};
    endfunction

    function automatic longint sat(input longint x, input int w, output bit c);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        c  = (x > hi) || (x < lo);
        return (x > hi) ? hi : (x < lo) ? lo : x;
    endfunction

    // Tile-level model: running sums, one output buffer, sticky saturation flag.
    longint m_acc [2][4];
    longint m_out [2][4];
    bit     m_ov  [2];
    bit     m_ovf [2];
    bit     m_st  [2];
    bit     m_busy[2];
    bit     started = 1'b0;

    always @(posedge clk) begin
        bit     stl, fire, cl, c1;
        longint s [4];
        started = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int l = 0; l < 4; l++) begin m_acc[d][l] = 0; m_out[d][l] = 0; end
                m_ov[d] = 0; m_ovf[d] = 0; m_st[d] = 0; m_busy[d] = 0;
            end else begin
                stl  = m_ov[d] && !out_ready[d];
                fire = in_valid[d] && !stl;
                if (m_ov[d] && out_ready[d]) m_ov[d] = 0;
                if (fire) begin
                    cl = 0;
                    for (int l = 0; l < 4; l++) begin
                        s[l] = sat(m_acc[d][l] + longint'(in_v[d][l]), accw[d], c1);
                        cl |= c1;
                    end
                    if (in_last[d]) begin
                        for (int l = 0; l < 4; l++) begin m_out[d][l] = s[l]; m_acc[d][l] = 0; end
                        m_ovf[d] = m_st[d] | cl; m_ov[d] = 1; m_st[d] = 0; m_busy[d] = 0;
                    end else begin
                        for (int l = 0; l < 4; l++) m_acc[d][l] = s[l];
                        m_st[d] = m_st[d] | cl; m_busy[d] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        bit [3:0] f;
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                f = dut_flags(d);
                chk($sformatf("d%0d stall", d), longint'(f[3]), longint'(m_ov[d] && !out_ready[d]));
                chk($sformatf("d%0d out_valid", d), longint'(f[2]), longint'(m_ov[d]));
                chk($sformatf("d%0d busy", d), longint'(f[1]), longint'(m_busy[d]));
                chk($sformatf("d%0d out_ovf", d), longint'(f[0]), longint'(m_ovf[d]));
                for (int l = 0; l < 4; l++)
                    chk($sformatf("d%0d out_vals[%0d]", d, l), dut_val(d, l), m_out[d][l]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input bit v, input bit last,
                         input int a, input int b, input int c, input int e);
        in_valid[d] = v;
        in_last[d]  = last;
        in_v[d][0]  = a; in_v[d][1] = b; in_v[d][2] = c; in_v[d][3] = e;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        out_ready[0] = 1; out_ready[1] = 1;
        rst = 1; step(); step(); rst = 0;
        chk("reset out_valid", longint'(bus0.out_valid), 0);
        chk("reset stall",     longint'(bus0.stall), 0);
        chk("reset busy",      longint'(bus0.busy), 0);
        chk("reset out_vals",  longint'(bus0.out_vals), 0);

        // in_last without in_valid does nothing
        drive(0, 0, 1, 9, 9, 9, 9); step();
        chk("idle last", longint'(bus0.out_valid), 0);

        // 9-beat 3x3 kernel tile
        for (int i = 0; i < 9; i++) begin drive(0, 1, i == 8, 5, 5, 5, 5); step(); end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("nine-beat valid", longint'(bus0.out_valid), 1);
        chk("nine-beat val",   dut_val(0, 3), 45);
        chk("nine-beat model", m_out[0][0], 45);
        chk("nine-beat ovf",   longint'(bus0.out_ovf), 0);
        step();

        // signed mix, including most-negative inputs
        drive(0, 1, 0, -7, 1, -32768, 32767); step();
        drive(0, 1, 0,  3, 2, -32768, 32767); step();
        drive(0, 1, 1, -1, 3, -32768, 32767); step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("signed raw", longint'(bus0.out_vals[0][0]), 64'h0000_0000_FFFF_FFFB);
        chk("signed neg", dut_val(0, 2), -98304);
        chk("signed pos", dut_val(0, 3), 98301);
        step();

        // backpressure: held beat counted exactly once
        out_ready[0] = 0;
        drive(0, 1, 1, 9, 9, 9, 9); step();
        chk("bp stall", longint'(bus0.stall), 1);
        drive(0, 1, 0, 2, 2, 2, 2);
        step(); step(); step();
        chk("bp ignored", longint'(bus0.busy), 0);
        chk("bp hold",    dut_val(0, 0), 9);
        out_ready[0] = 1;
        #1 chk("bp release", longint'(bus0.stall), 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("bp taken", longint'(bus0.busy), 1);
        drive(0, 1, 1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("bp once", dut_val(0, 1), 2);
        step();

        // back-to-back single-beat tiles
        for (int k = 1; k <= 3; k++) begin
            drive(0, 1, 1, k, k, k, k); step();
            chk("b2b val",   dut_val(0, 3), k);
            chk("b2b valid", longint'(bus0.out_valid), 1);
            chk("b2b stall", longint'(bus0.stall), 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0); step();

        // saturation at ACC_W = IN_W + 1
        drive(1, 1, 0, 127, -128, 0, 127);  step();
        drive(1, 1, 0, 127, -128, 0, -128); step();
        drive(1, 1, 1, 127, -128, 0, 127);  step();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("sat max", dut_val(1, 0), 255);
        chk("sat min", dut_val(1, 1), -256);
        chk("sat mix", dut_val(1, 3), 126);
        chk("sat ovf", longint'(bus1.out_ovf), 1);
        step();
        drive(1, 1, 1, 1, 1, 1, 1); step();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("clean val", dut_val(1, 0), 1);
        chk("clean ovf", longint'(bus1.out_ovf), 0);
        step();

        // reset mid-tile discards the partial sum
        for (int i = 0; i < 4; i++) begin drive(0, 1, 0, 5, 5, 5, 5); step(); end
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1; step(); rst = 0;
        chk("mid-rst busy", longint'(bus0.busy), 0);
        drive(0, 1, 0, 1, 1, 1, 1); step();
        drive(0, 1, 1, 1, 1, 1, 1); step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("mid-rst val",   dut_val(0, 0), 2);
        chk("mid-rst model", m_out[0][0], 2);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
